// File: rtl/time_set_pkg.sv
// ============================================================================
// Module   : time_set_pkg
// Purpose  : Shared types and constants for the clock time-set controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package time_set_pkg;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_SET_HR  = 2'd1,
        MODE_SET_MIN = 2'd2,
        MODE_SET_SEC = 2'd3
    } mode_e;

    // tick_2hz ticks a button must stay held before auto-repeat starts
    localparam int BLINK_HOLD_TICKS = 2;

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_RUN:     return MODE_SET_HR;
            MODE_SET_HR:  return MODE_SET_MIN;
            MODE_SET_MIN: return MODE_SET_SEC;
            default:      return MODE_RUN;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/time_set_controller_if.sv
// ============================================================================
// Module   : time_set_controller_if
// Purpose  : Buttons/timebase in, step pulses and display blanking out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface time_set_controller_if;
    logic       tick_1hz;
    logic       tick_2hz;
    logic       btn_mode;
    logic       btn_up;
    logic       btn_down;
    logic       sec_tc;
    logic       min_tc;
    logic       step_sec;
    logic       step_min;
    logic       step_hr;
    logic       dir_up;
    logic [1:0] mode;
    logic       blank_hr;
    logic       blank_min;
    logic       blank_sec;

    // master: the controller, which issues steps to the counter bank
    modport master (
        input  tick_1hz, tick_2hz, btn_mode, btn_up, btn_down, sec_tc, min_tc,
        output step_sec, step_min, step_hr, dir_up, mode,
        output blank_hr, blank_min, blank_sec
    );

    modport slave (
        output tick_1hz, tick_2hz, btn_mode, btn_up, btn_down, sec_tc, min_tc,
        input  step_sec, step_min, step_hr, dir_up, mode,
        input  blank_hr, blank_min, blank_sec
    );
endinterface

`default_nettype wire

// File: rtl/btn_edge.sv
// ============================================================================
// Module   : btn_edge
// Purpose  : Sample + history register pair giving a one-cycle rising edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_edge (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic btn,
    output logic      level,
    output logic      rise
);
    logic r_sample;
    logic r_hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sample <= 1'b0;
            r_hist   <= 1'b0;
        end else begin
            r_sample <= btn;
            r_hist   <= r_sample;
        end
    end

    assign level = r_sample;
    assign rise  = r_sample & ~r_hist;
endmodule

`default_nettype wire

// File: rtl/time_set_controller.sv
// ============================================================================
// Module   : time_set_controller
// Purpose  : Run/set mode sequencer for the BCD time counters. Optional
//            hold-to-repeat stepping is enabled by TIME_SET_AUTOREPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module time_set_controller #(
    parameter int TIMEOUT_S = 10
) (
    input wire logic               clk,
    input wire logic               reset,
    time_set_controller_if.master  bus
);
    import time_set_pkg::*;

    localparam int              c_tw     = (TIMEOUT_S > 0) ? $clog2(TIMEOUT_S + 1) : 1;
    localparam logic [c_tw-1:0] c_reload = c_tw'(TIMEOUT_S);

    logic w_mode_edge, w_up_edge, w_down_edge;
    logic w_mode_lvl, w_up_lvl, w_down_lvl;

    btn_edge u_mode (.clk(clk), .reset(reset), .btn(bus.btn_mode), .level(w_mode_lvl), .rise(w_mode_edge));
    btn_edge u_up   (.clk(clk), .reset(reset), .btn(bus.btn_up),   .level(w_up_lvl),   .rise(w_up_edge));
    btn_edge u_down (.clk(clk), .reset(reset), .btn(bus.btn_down), .level(w_down_lvl), .rise(w_down_edge));

    mode_e           r_state;
    logic            r_phase;
    logic [c_tw-1:0] r_tcount;
    logic            r_step_sec, r_step_min, r_step_hr, r_dir_up;
    logic            r_blank_hr, r_blank_min, r_blank_sec;

    logic  w_set, w_tmo, w_man_step, w_rep_step, w_rep_up, w_step_req, w_step_up;
    mode_e w_state_nxt;
    logic  w_phase_nxt;
    logic  w_unused_mode;

    assign w_unused_mode = w_mode_lvl;
    assign w_set      = (r_state != MODE_RUN);
    assign w_tmo      = w_set && (TIMEOUT_S != 0) && bus.tick_1hz && (r_tcount == c_tw'(1));
    // simultaneous up+down cancel; a mode edge swallows either
    assign w_man_step = w_set && (w_up_edge ^ w_down_edge) && !w_mode_edge;
    assign w_step_req = !w_tmo && !w_mode_edge && (w_man_step || w_rep_step);
    assign w_step_up  = w_man_step ? w_up_edge : w_rep_up;

    always_comb begin
        w_state_nxt = r_state;
        if (w_mode_edge) begin
            w_state_nxt = next_mode(r_state);
        end else if (w_tmo) begin
            w_state_nxt = MODE_RUN;
        end
        w_phase_nxt = r_phase;
        if (w_state_nxt != r_state) begin
            w_phase_nxt = 1'b0;
        end else if (bus.tick_2hz) begin
            w_phase_nxt = ~r_phase;
        end
    end

`ifdef TIME_SET_AUTOREPEAT_EN
    localparam int              c_hw   = $clog2(BLINK_HOLD_TICKS + 1);
    localparam logic [c_hw-1:0] c_hold = c_hw'(BLINK_HOLD_TICKS);

    logic            r_rep_arm;
    logic            r_rep_up;
    logic [c_hw-1:0] r_hold_cnt;
    logic            w_rep_held;

    // the repeating button must stay down alone; both held never repeats
    assign w_rep_held = r_rep_up ? (w_up_lvl & ~w_down_lvl) : (w_down_lvl & ~w_up_lvl);
    assign w_rep_step = r_rep_arm && w_rep_held && bus.tick_2hz && (r_hold_cnt == c_hold);
    assign w_rep_up   = r_rep_up;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rep_arm  <= 1'b0;
            r_rep_up   <= 1'b1;
            r_hold_cnt <= '0;
        end else if (w_step_req && w_man_step) begin
            r_rep_arm  <= 1'b1;
            r_rep_up   <= w_up_edge;
            r_hold_cnt <= '0;
        end else if ((w_state_nxt != r_state) || !w_rep_held) begin
            r_rep_arm  <= 1'b0;
            r_hold_cnt <= '0;
        end else if (r_rep_arm && bus.tick_2hz && (r_hold_cnt != c_hold)) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end
`else
    logic w_unused_lvl;

    assign w_rep_step   = 1'b0;
    assign w_rep_up     = 1'b1;
    assign w_unused_lvl = &{1'b0, w_up_lvl, w_down_lvl};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= MODE_RUN;
            r_phase     <= 1'b0;
            r_tcount    <= '0;
            r_step_sec  <= 1'b0;
            r_step_min  <= 1'b0;
            r_step_hr   <= 1'b0;
            r_dir_up    <= 1'b1;
            r_blank_hr  <= 1'b0;
            r_blank_min <= 1'b0;
            r_blank_sec <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_phase    <= w_phase_nxt;
            r_step_sec <= 1'b0;
            r_step_min <= 1'b0;
            r_step_hr  <= 1'b0;

            if (r_state == MODE_RUN) begin
                if (bus.tick_1hz) begin
                    r_step_sec <= 1'b1;
                    r_step_min <= bus.sec_tc;
                    r_step_hr  <= bus.sec_tc & bus.min_tc;
                    r_dir_up   <= 1'b1;
                end
            end else if (w_step_req) begin
                case (r_state)
                    MODE_SET_HR:  r_step_hr  <= 1'b1;
                    MODE_SET_MIN: r_step_min <= 1'b1;
                    default:      r_step_sec <= 1'b1;
                endcase
                r_dir_up <= w_step_up;
            end

            if (w_mode_edge && (w_state_nxt != MODE_RUN)) begin
                r_tcount <= c_reload;
            end else if (w_state_nxt == MODE_RUN) begin
                r_tcount <= '0;
            end else if (w_step_req) begin
                r_tcount <= c_reload;
            end else if (bus.tick_1hz && (r_tcount != '0)) begin
                r_tcount <= r_tcount - 1'b1;
            end

            r_blank_hr  <= (w_state_nxt == MODE_SET_HR)  & w_phase_nxt;
            r_blank_min <= (w_state_nxt == MODE_SET_MIN) & w_phase_nxt;
            r_blank_sec <= (w_state_nxt == MODE_SET_SEC) & w_phase_nxt;
        end
    end

    assign bus.step_sec  = r_step_sec;
    assign bus.step_min  = r_step_min;
    assign bus.step_hr   = r_step_hr;
    assign bus.dir_up    = r_dir_up;
    assign bus.mode      = r_state;
    assign bus.blank_hr  = r_blank_hr;
    assign bus.blank_min = r_blank_min;
    assign bus.blank_sec = r_blank_sec;
endmodule

`default_nettype wire
